// File: rtl/periphery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periphery_pkg
// Purpose  : Shared PRU periphery definitions: pad bus widths, the PRU NOP
//            opcode, host command kinds, response status codes and the host
//            sequencer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package periphery_pkg;

  // PRU pad bus widths
  localparam int IO_OPCODE_L   = 4;
  localparam int INPUT_DATA_L  = 32;
  localparam int OUTPUT_DATA_L = 32;

  // Opcode the PRU treats as "no operation"; driven whenever the pins idle
  localparam logic [IO_OPCODE_L-1:0] IO_OPCODE_NOP = '0;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_READ  = 2'd2,
    CMD_NOP   = 2'd3
  } cmd_kind_e;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_TIMEOUT = 2'd1
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRIVE     = 3'd1,
    ST_RST_PULSE = 3'd2,
    ST_RUN       = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_RSP       = 3'd5
  } seq_state_e;

  // Cycle-count parameters of 0 are treated as 1
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single asynchronous level signal.
// Ports    : clk   - destination clock
//            rst   - asynchronous active-low reset (both flops clear to 0)
//            d     - asynchronous input
//            q     - synchronised output, two clk edges after d
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/io_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_host_sequencer
// Purpose  : Converts host commands (WRITE / RUN / READ / NOP) into timed
//            activity on the PRU pad inputs and returns responses for RUN
//            and READ.
// Ports    : clk, rst (async active-low)
//            cmd_valid/cmd_ready, cmd_kind, cmd_opcode, cmd_data - command in
//            rsp_valid/rsp_ready, rsp_data, rsp_status          - response out
//            pru_in, pru_io_opcode, pru_reset_execution,
//            pru_enable_execution                                - PRU drive
//            pru_done_execution, pru_out                         - PRU sense
// Config   : IO_SEQ_TIMEOUT_EN - when defined, a RUN without done for
//            TIMEOUT_CYCLES cycles ends with status TIMEOUT; when undefined
//            RUN waits for done indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module io_host_sequencer
  import periphery_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  logic [IO_OPCODE_L-1:0]   cmd_opcode,
  input  logic [INPUT_DATA_L-1:0]  cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OUTPUT_DATA_L-1:0] rsp_data,
  output logic [1:0]               rsp_status,
  output logic [INPUT_DATA_L-1:0]  pru_in,
  output logic [IO_OPCODE_L-1:0]   pru_io_opcode,
  output logic                     pru_reset_execution,
  output logic                     pru_enable_execution,
  input  logic                     pru_done_execution,
  input  logic [OUTPUT_DATA_L-1:0] pru_out
);

  localparam int unsigned c_hold_eff = at_least_one(HOLD_CYCLES);
  localparam int unsigned c_lat_eff  = at_least_one(READ_LAT);
  localparam int unsigned c_cnt_max  = (c_hold_eff > c_lat_eff) ? c_hold_eff : c_lat_eff;
  localparam int          c_cnt_w    = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  // The hold counter is loaded with N-1 and the state exits when it reads 0
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(c_hold_eff - 1);
  localparam logic [c_cnt_w-1:0] c_lat_load  = c_cnt_w'(c_lat_eff - 1);

  seq_state_e                r_state;
  seq_state_e                w_state_next;
  cmd_kind_e                 r_kind;
  logic [IO_OPCODE_L-1:0]    r_opcode;
  logic [INPUT_DATA_L-1:0]   r_data;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [OUTPUT_DATA_L-1:0]  r_rsp_data;
  logic [1:0]                r_rsp_status;
  logic                      r_live;
  logic                      w_accept;
  logic                      w_done_sync;
  logic                      w_timeout;
  logic                      w_cnt_zero;

  sync_2ff u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (pru_done_execution),
    .q   (w_done_sync)
  );

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // Goes high on the first edge after reset release and stays there, so
  // cmd_ready is held low while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

`ifdef IO_SEQ_TIMEOUT_EN
  localparam int unsigned        c_to_eff  = at_least_one(TIMEOUT_CYCLES);
  localparam int                 c_to_w    = (c_to_eff > 1) ? $clog2(c_to_eff) : 1;
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(c_to_eff - 1);

  logic [c_to_w-1:0] r_run_cnt;

  // Counts completed RUN cycles; reaching c_to_last means this is the
  // TIMEOUT_CYCLES-th enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_run_cnt <= '0;
    else if (r_state != ST_RUN) r_run_cnt <= '0;
    else if (!w_timeout)        r_run_cnt <= r_run_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_RUN) && (r_run_cnt == c_to_last);
`else
  localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_kind_e'(cmd_kind))
            CMD_RUN:  w_state_next = ST_RST_PULSE;
            CMD_READ: w_state_next = ST_READ_WAIT;
            // NOP rides through DRIVE for a single cycle with pins idle
            default:  w_state_next = ST_DRIVE;
          endcase
        end
      end
      ST_DRIVE:     if (w_cnt_zero) w_state_next = ST_IDLE;
      ST_RST_PULSE: w_state_next = ST_RUN;
      ST_RUN:       if (w_done_sync || w_timeout) w_state_next = ST_RSP;
      ST_READ_WAIT: if (w_cnt_zero) w_state_next = ST_RSP;
      ST_RSP:       if (rsp_ready) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    cmd_ready            = (r_state == ST_IDLE) && r_live;
    rsp_valid            = (r_state == ST_RSP);
    pru_io_opcode        = IO_OPCODE_NOP;
    pru_in               = '0;
    pru_reset_execution  = 1'b0;
    pru_enable_execution = 1'b0;
    case (r_state)
      ST_DRIVE: begin
        if (r_kind == CMD_WRITE) begin
          pru_io_opcode = r_opcode;
          pru_in        = r_data;
        end
      end
      ST_READ_WAIT: pru_io_opcode        = r_opcode;
      ST_RST_PULSE: pru_reset_execution  = 1'b1;
      ST_RUN:       pru_enable_execution = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kind   <= CMD_NOP;
      r_opcode <= '0;
      r_data   <= '0;
    end else if (w_accept) begin
      r_kind   <= cmd_kind_e'(cmd_kind);
      r_opcode <= cmd_opcode;
      r_data   <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      case (cmd_kind_e'(cmd_kind))
        CMD_WRITE: r_cnt <= c_hold_load;
        CMD_READ:  r_cnt <= c_lat_load;
        default:   r_cnt <= '0;
      endcase
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Done takes priority over a timeout landing in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_data   <= '0;
      r_rsp_status <= STATUS_OK;
    end else if ((r_state == ST_RUN) && (w_done_sync || w_timeout)) begin
      r_rsp_data   <= '0;
      r_rsp_status <= w_done_sync ? STATUS_OK : STATUS_TIMEOUT;
    end else if ((r_state == ST_READ_WAIT) && w_cnt_zero) begin
      r_rsp_data   <= pru_out;
      r_rsp_status <= STATUS_OK;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_host_sequencer
// Purpose  : Self-checking bench for io_host_sequencer. Expected responses
//            are queued as commands are issued and a monitor compares them
//            whenever rsp_valid is presented; pin timing is checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_host_sequencer;
  import periphery_pkg::*;

`ifdef IO_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1048575;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = 2'd3;
  logic [3:0]  cmd_opcode = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [31:0] pru_in;
  logic [3:0]  pru_io_opcode;
  logic        pru_reset_execution;
  logic        pru_enable_execution;
  logic        pru_done_execution = 1'b0;
  logic [31:0] pru_out = 32'h1234_5678;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  io_host_sequencer #(
    .HOLD_CYCLES    (2),
    .READ_LAT       (2),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_kind             (cmd_kind),
    .cmd_opcode           (cmd_opcode),
    .cmd_data             (cmd_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data             (rsp_data),
    .rsp_status           (rsp_status),
    .pru_in               (pru_in),
    .pru_io_opcode        (pru_io_opcode),
    .pru_reset_execution  (pru_reset_execution),
    .pru_enable_execution (pru_enable_execution),
    .pru_done_execution   (pru_done_execution),
    .pru_out              (pru_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Response monitor: every cycle a response is presented it must match the
  // head of the expected queue; the entry retires when rsp_ready accepts it.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h status %0d, expected no response (t=%0t)",
                 rsp_data, rsp_status, $time);
      end else begin
        chk("rsp_data", rsp_data, exp_q[0].data);
        chk("rsp_status", {30'd0, rsp_status}, {30'd0, exp_q[0].status});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present a command from a negedge and hold it until accepted.
  // Returns just after the accepting posedge.
  task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_kind   = k;
    cmd_opcode = op;
    cmd_data   = d;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 within 200 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic chk_pins_idle(input string tag);
    chk({tag, "_opcode"}, {28'd0, pru_io_opcode}, 32'd0);
    chk({tag, "_pru_in"}, pru_in, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // ---------------- reset state
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    chk_pins_idle("rst");
    chk("rst_reset_exec", {31'd0, pru_reset_execution}, 32'd0);
    chk("rst_enable", {31'd0, pru_enable_execution}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rel_cmd_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("rel_cmd_ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    // ---------------- WRITE opcode 3 / 0xDEADBEEF held 2 cycles
    send(2'd0, 4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_c1_opcode", {28'd0, pru_io_opcode}, 32'd3);
    chk("wr_c1_data", pru_in, 32'hDEAD_BEEF);
    chk("wr_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("wr_c2_opcode", {28'd0, pru_io_opcode}, 32'd3);
    chk("wr_c2_data", pru_in, 32'hDEAD_BEEF);
    @(negedge clk);
    chk_pins_idle("wr_after");
    chk("wr_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // ---------------- RUN with done 10 cycles after enable
    exp_q.push_back('{data: 32'd0, status: 2'd0});
    send(2'd1, 4'd0, 32'd0);
    @(negedge clk);
    chk("run_reset_pulse", {31'd0, pru_reset_execution}, 32'd1);
    chk("run_enable_in_pulse", {31'd0, pru_enable_execution}, 32'd0);
    chk("run_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("run_reset_pulse_end", {31'd0, pru_reset_execution}, 32'd0);
    chk("run_enable_on", {31'd0, pru_enable_execution}, 32'd1);
    repeat (10) @(posedge clk);
    #1 pru_done_execution = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_enable_still_on", {31'd0, pru_enable_execution}, 32'd1);
    @(negedge clk);
    chk("run_enable_off", {31'd0, pru_enable_execution}, 32'd0);
    chk("run_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1 pru_done_execution = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- READ opcode 5, response back-pressured 5 cycles
    rsp_ready = 1'b0;
    pru_out   = 32'h1234_5678;
    exp_q.push_back('{data: 32'h1234_5678, status: 2'd0});
    send(2'd2, 4'd5, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rd_c1_opcode", {28'd0, pru_io_opcode}, 32'd5);
    chk("rd_c1_pru_in", pru_in, 32'd0);
    @(negedge clk);
    chk("rd_c2_opcode", {28'd0, pru_io_opcode}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    chk_pins_idle("rd_rsp");
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_valid_cleared", {31'd0, rsp_valid}, 32'd0);
    chk("rd_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

`ifdef IO_SEQ_TIMEOUT_EN
    // ---------------- RUN that never completes
    exp_q.push_back('{data: 32'd0, status: 2'd1});
    send(2'd1, 4'd0, 32'd0);
    @(negedge clk);
    chk("to_reset_pulse", {31'd0, pru_reset_execution}, 32'd1);
    repeat (16) @(negedge clk);
    chk("to_enable_last", {31'd0, pru_enable_execution}, 32'd1);
    @(negedge clk);
    chk("to_enable_off", {31'd0, pru_enable_execution}, 32'd0);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    repeat (2) @(negedge clk);
`endif

    // ---------------- reset asserted mid-RUN
    send(2'd1, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("mr_enable_before", {31'd0, pru_enable_execution}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_enable_dropped", {31'd0, pru_enable_execution}, 32'd0);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    send(2'd0, 4'hA, 32'h0BAD_F00D);
    @(negedge clk);
    chk("mr_wr_opcode", {28'd0, pru_io_opcode}, 32'hA);
    chk("mr_wr_data", pru_in, 32'h0BAD_F00D);
    @(negedge clk);
    @(negedge clk);
    chk_pins_idle("mr_wr_after");

    // ---------------- done pulse while IDLE, then NOP
    @(posedge clk);
    #1 pru_done_execution = 1'b1;
    repeat (2) @(posedge clk);
    #1 pru_done_execution = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_done_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("idle_done_enable", {31'd0, pru_enable_execution}, 32'd0);
    send(2'd3, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("nop_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    chk_pins_idle("nop");
    chk("nop_enable", {31'd0, pru_enable_execution}, 32'd0);
    chk("nop_reset_exec", {31'd0, pru_reset_execution}, 32'd0);
    @(negedge clk);
    chk("nop_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk_pins_idle("nop_after");
    repeat (4) @(negedge clk);
    chk("nop_no_rsp", {31'd0, rsp_valid}, 32'd0);

    chk("exp_queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
